// File: rtl/blinker_pkg.sv
// blinker_pkg
// Shared constants for the LED bank arbiter slice:
//   - FSM state encoding (IDLE, OWN0, OWN1)
//   - slice counter width
//   - default ownership slice length (1 s at 12 MHz)
package blinker_pkg;

  localparam logic [1:0] IDLE = 2'd0;
  localparam logic [1:0] OWN0 = 2'd1;
  localparam logic [1:0] OWN1 = 2'd2;

  localparam int unsigned CNT_W               = 24;
  localparam int unsigned HOLD_CYCLES_DEFAULT = 12000000;

endpackage

// File: rtl/led_slice_timer.sv
// led_slice_timer
// Ownership slice counter. Counts up while enabled and parks at LIMIT so a
// long-held owner can be displaced as soon as the other side asks.
// Ports:
//   clk_i      - clock, rising edge
//   rst_ni     - asynchronous active-low reset, clears the count
//   clear_i    - synchronous clear, wins over enable
//   enable_i   - count this cycle
//   at_limit_o - count currently equals LIMIT
module led_slice_timer
  import blinker_pkg::*;
#(
  parameter int unsigned LIMIT = HOLD_CYCLES_DEFAULT - 1
) (
  input  logic clk_i,
  input  logic rst_ni,
  input  logic clear_i,
  input  logic enable_i,
  output logic at_limit_o
);

  localparam logic [CNT_W-1:0] LimitVal = CNT_W'(LIMIT);

  logic [CNT_W-1:0] cnt_q;
  logic [CNT_W-1:0] cnt_d;

  // Clear has priority; otherwise count up and stop at the limit.
  always_comb begin
    cnt_d = cnt_q;
    if (clear_i) begin
      cnt_d = '0;
    end else if (enable_i && (cnt_q != LimitVal)) begin
      cnt_d = cnt_q + CNT_W'(1);
    end
  end

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      cnt_q <= '0;
    end else begin
      cnt_q <= cnt_d;
    end
  end

  assign at_limit_o = (cnt_q == LimitVal);

endmodule

// File: rtl/led_bank_arbiter.sv
// led_bank_arbiter
// Two-requester arbiter for one 8-bit LED bank. The owner drives the LEDs;
// under contention ownership alternates after HOLD_CYCLES cycles, while a
// voluntary release hands over on the next edge.
// Ports:
//   clk           - clock, rising edge
//   NOTRESET      - asynchronous active-low reset
//   REQ0/REQ1     - level requests, held until released
//   DATA0/DATA1   - LED patterns of each requester
//   GNT0/GNT1     - registered grants, mutually exclusive
//   LED7..LED0    - registered LED drives, one cycle behind the grant
// Optional feature macro: LED_BANK_IDLE_HEARTBEAT_EN
//   When defined, LED0 blinks with period 2*HOLD_CYCLES while idle.
module led_bank_arbiter
  import blinker_pkg::*;
#(
  parameter int unsigned HOLD_CYCLES = HOLD_CYCLES_DEFAULT
) (
  input  logic       clk,
  input  logic       NOTRESET,
  input  logic       REQ0,
  input  logic [7:0] DATA0,
  input  logic       REQ1,
  input  logic [7:0] DATA1,
  output logic       GNT0,
  output logic       GNT1,
  output logic       LED7,
  output logic       LED6,
  output logic       LED5,
  output logic       LED4,
  output logic       LED3,
  output logic       LED2,
  output logic       LED1,
  output logic       LED0
);

  logic [1:0] state_q;
  logic [1:0] state_d;
  logic       last_q;
  logic       last_d;
  logic       gnt0_q;
  logic       gnt1_q;
  logic [7:0] led_q;
  logic [7:0] led_d;
  logic [7:0] idle_led;
  logic       at_limit;
  logic       grant_change;
  logic       timer_clear;
  logic       timer_en;

  led_slice_timer #(
    .LIMIT(HOLD_CYCLES - 1)
  ) u_slice_timer (
    .clk_i     (clk),
    .rst_ni    (NOTRESET),
    .clear_i   (timer_clear),
    .enable_i  (timer_en),
    .at_limit_o(at_limit)
  );

  // Arbitration. A tie from IDLE goes to whoever did not own last; a
  // contended owner only yields once its slice has run out.
  always_comb begin
    state_d = state_q;
    case (state_q)
      IDLE: begin
        if (REQ0 && REQ1)  state_d = last_q ? OWN0 : OWN1;
        else if (REQ0)     state_d = OWN0;
        else if (REQ1)     state_d = OWN1;
      end
      OWN0: begin
        if (!REQ0)                 state_d = REQ1 ? OWN1 : IDLE;
        else if (REQ1 && at_limit) state_d = OWN1;
      end
      OWN1: begin
        if (!REQ1)                 state_d = REQ0 ? OWN0 : IDLE;
        else if (REQ0 && at_limit) state_d = OWN0;
      end
      default: state_d = IDLE;
    endcase
  end

  assign grant_change = (state_d != state_q);

  // Remember the most recent owner for tie-breaking.
  always_comb begin
    last_d = last_q;
    if (grant_change && (state_d == OWN0)) last_d = 1'b0;
    if (grant_change && (state_d == OWN1)) last_d = 1'b1;
  end

`ifdef LED_BANK_IDLE_HEARTBEAT_EN
  logic hb_q;
  logic hb_d;
  logic hb_wrap;

  // While idle the slice counter doubles as the heartbeat divider: each time
  // it reaches the limit LED0 flips and the count restarts. Holding the
  // phase at 0 while owned makes every idle period start from 0.
  assign hb_wrap = (state_q == IDLE) && at_limit;

  always_comb begin
    hb_d = hb_q;
    if (state_q != IDLE) hb_d = 1'b0;
    else if (hb_wrap)    hb_d = ~hb_q;
  end

  always_ff @(posedge clk or negedge NOTRESET) begin
    if (!NOTRESET) hb_q <= 1'b0;
    else           hb_q <= hb_d;
  end

  assign idle_led    = {7'b0, hb_q};
  assign timer_en    = 1'b1;
  assign timer_clear = grant_change || hb_wrap;
`else
  assign idle_led    = 8'h00;
  assign timer_en    = (state_q != IDLE);
  assign timer_clear = grant_change;
`endif

  // LEDs follow the registered grant, hence the one-cycle lag behind GNT.
  always_comb begin
    led_d = idle_led;
    if (gnt0_q)      led_d = DATA0;
    else if (gnt1_q) led_d = DATA1;
  end

  always_ff @(posedge clk or negedge NOTRESET) begin
    if (!NOTRESET) begin
      state_q <= IDLE;
      last_q  <= 1'b1;
      gnt0_q  <= 1'b0;
      gnt1_q  <= 1'b0;
      led_q   <= 8'h00;
    end else begin
      state_q <= state_d;
      last_q  <= last_d;
      gnt0_q  <= (state_d == OWN0);
      gnt1_q  <= (state_d == OWN1);
      led_q   <= led_d;
    end
  end

  assign GNT0 = gnt0_q;
  assign GNT1 = gnt1_q;
  assign {LED7, LED6, LED5, LED4, LED3, LED2, LED1, LED0} = led_q;

endmodule

// File: tb/tb_led_bank_arbiter.sv
// tb_led_bank_arbiter
// Self-checking bench for led_bank_arbiter with HOLD_CYCLES = 4.
// Table vectors drive one clock each; the expected outputs for that edge are
// queued when driven and compared one step after the rising edge.
module tb_led_bank_arbiter;

  localparam int unsigned HoldCycles = 4;
`ifdef LED_BANK_IDLE_HEARTBEAT_EN
  localparam logic [7:0] IdleMask = 8'hFE;
`else
  localparam logic [7:0] IdleMask = 8'hFF;
`endif

  logic       clk = 1'b0;
  logic       notReset;
  logic       req0;
  logic       req1;
  logic [7:0] data0;
  logic [7:0] data1;
  logic       gnt0;
  logic       gnt1;
  logic [7:0] leds;

  typedef struct {
    logic       rst;
    logic       r0;
    logic       r1;
    logic [7:0] d0;
    logic [7:0] d1;
    logic       g0;
    logic       g1;
    logic [7:0] led;
    logic       idle;
  } vec_t;

  typedef struct {
    logic       g0;
    logic       g1;
    logic [7:0] led;
    logic       idle;
    int         idx;
  } exp_t;

  vec_t vecs[$];
  exp_t sb[$];
  int   passCount  = 0;
  int   checkCount = 0;

  always #5 clk = ~clk;

  led_bank_arbiter #(
    .HOLD_CYCLES(HoldCycles)
  ) dut (
    .clk     (clk),
    .NOTRESET(notReset),
    .REQ0    (req0),
    .DATA0   (data0),
    .REQ1    (req1),
    .DATA1   (data1),
    .GNT0    (gnt0),
    .GNT1    (gnt1),
    .LED7    (leds[7]),
    .LED6    (leds[6]),
    .LED5    (leds[5]),
    .LED4    (leds[4]),
    .LED3    (leds[3]),
    .LED2    (leds[2]),
    .LED1    (leds[1]),
    .LED0    (leds[0])
  );

  // Hard stop in case something stalls the stimulus.
  initial begin
    #200000;
    $display("[TB] FAIL watchdog: got timeout, wanted completion");
    $fatal(1, "[TB] watchdog expired");
  end

  function automatic void addVec(input logic rst, input logic r0, input logic r1,
                                 input logic [7:0] d0, input logic [7:0] d1,
                                 input logic g0, input logic g1,
                                 input logic [7:0] led, input logic idle);
    vec_t v;
    v.rst = rst; v.r0 = r0; v.r1 = r1; v.d0 = d0; v.d1 = d1;
    v.g0 = g0; v.g1 = g1; v.led = led; v.idle = idle;
    vecs.push_back(v);
  endfunction

  task automatic check(input string name, input logic [7:0] actual,
                       input logic [7:0] expected, input logic [7:0] mask);
    checkCount++;
    if ((actual & mask) === (expected & mask)) passCount++;
    else $display("[TB] FAIL %s: got %02h, wanted %02h", name, actual & mask, expected & mask);
  endtask

  // Hold reset across one edge, confirm the reset state, release on a
  // falling edge so the next rising edge is the first active one.
  task automatic doReset();
    @(negedge clk);
    notReset = 1'b0;
    req0 = 1'b0; req1 = 1'b0; data0 = 8'h00; data1 = 8'h00;
    @(posedge clk);
    #1;
    check("reset_gnt0", {7'b0, gnt0}, 8'h00, 8'hFF);
    check("reset_gnt1", {7'b0, gnt1}, 8'h00, 8'hFF);
    check("reset_leds", leds, 8'h00, 8'hFF);
    @(negedge clk);
    notReset = 1'b1;
  endtask

  task automatic applyStimulus(input vec_t v, input int idx);
    exp_t e;
    if (v.rst) doReset();
    else       @(negedge clk);
    req0 = v.r0; req1 = v.r1; data0 = v.d0; data1 = v.d1;
    e.g0 = v.g0; e.g1 = v.g1; e.led = v.led; e.idle = v.idle; e.idx = idx;
    sb.push_back(e);
  endtask

  task automatic checkOutput();
    exp_t e;
    @(posedge clk);
    #1;
    if (sb.size() == 0) begin
      checkCount++;
      $display("[TB] FAIL scoreboard: got empty queue, wanted an entry");
    end else begin
      e = sb.pop_front();
      check($sformatf("vec%0d_gnt0", e.idx), {7'b0, gnt0}, {7'b0, e.g0}, 8'hFF);
      check($sformatf("vec%0d_gnt1", e.idx), {7'b0, gnt1}, {7'b0, e.g1}, 8'hFF);
      check($sformatf("vec%0d_leds", e.idx), leds, e.led, e.idle ? IdleMask : 8'hFF);
      check($sformatf("vec%0d_exclusive", e.idx), {7'b0, gnt0 & gnt1}, 8'h00, 8'hFF);
    end
  endtask

  initial begin
    notReset = 1'b1;
    req0 = 1'b0; req1 = 1'b0; data0 = 8'h00; data1 = 8'h00;

    // Single requester: GNT at edge 1, LEDs at edge 2, live data updates,
    // non-owner data ignored, release returns to idle.
    addVec(1, 1, 0, 8'hA5, 8'h00, 1, 0, 8'h00, 1);
    addVec(0, 1, 0, 8'hA5, 8'h00, 1, 0, 8'hA5, 0);
    addVec(0, 1, 0, 8'h5A, 8'h00, 1, 0, 8'h5A, 0);
    addVec(0, 1, 0, 8'h5A, 8'hFF, 1, 0, 8'h5A, 0);
    addVec(0, 0, 0, 8'h5A, 8'hFF, 0, 0, 8'h5A, 0);
    addVec(0, 0, 0, 8'h5A, 8'hFF, 0, 0, 8'h00, 1);

    // Both request from reset: requester 0 first, then 4-cycle alternation.
    addVec(1, 1, 1, 8'h11, 8'h22, 1, 0, 8'h00, 1);
    addVec(0, 1, 1, 8'h11, 8'h22, 1, 0, 8'h11, 0);
    addVec(0, 1, 1, 8'h11, 8'h22, 1, 0, 8'h11, 0);
    addVec(0, 1, 1, 8'h11, 8'h22, 1, 0, 8'h11, 0);
    addVec(0, 1, 1, 8'h11, 8'h22, 0, 1, 8'h11, 0);
    addVec(0, 1, 1, 8'h11, 8'h22, 0, 1, 8'h22, 0);
    addVec(0, 1, 1, 8'h11, 8'h22, 0, 1, 8'h22, 0);
    addVec(0, 1, 1, 8'h11, 8'h22, 0, 1, 8'h22, 0);
    addVec(0, 1, 1, 8'h11, 8'h22, 1, 0, 8'h22, 0);
    addVec(0, 1, 1, 8'h11, 8'h22, 1, 0, 8'h11, 0);

    // Voluntary release by owner 1 hands over without waiting for the slice.
    addVec(1, 0, 1, 8'hC3, 8'h3C, 0, 1, 8'h00, 1);
    addVec(0, 1, 1, 8'hC3, 8'h3C, 0, 1, 8'h3C, 0);
    addVec(0, 1, 0, 8'hC3, 8'h3C, 1, 0, 8'h3C, 0);
    addVec(0, 1, 0, 8'hC3, 8'h3C, 1, 0, 8'hC3, 0);

    // Long ownership saturates the slice, so a late request wins at once.
    addVec(1, 1, 0, 8'h77, 8'h88, 1, 0, 8'h00, 1);
    for (int i = 0; i < 9; i++) addVec(0, 1, 0, 8'h77, 8'h88, 1, 0, 8'h77, 0);
    addVec(0, 1, 1, 8'h77, 8'h88, 0, 1, 8'h77, 0);
    addVec(0, 1, 1, 8'h77, 8'h88, 0, 1, 8'h88, 0);

    for (int i = 0; i < vecs.size(); i++) begin
      applyStimulus(vecs[i], i);
      checkOutput();
    end

    // Asynchronous reset in the middle of a clock period while owned by 1.
    doReset();
    req1 = 1'b1; data1 = 8'h99;
    repeat (3) @(posedge clk);
    #1;
    check("own1_before_reset_gnt1", {7'b0, gnt1}, 8'h01, 8'hFF);
    check("own1_before_reset_leds", leds, 8'h99, 8'hFF);
    #2;
    notReset = 1'b0;
    #1;
    check("async_reset_gnt1", {7'b0, gnt1}, 8'h00, 8'hFF);
    check("async_reset_gnt0", {7'b0, gnt0}, 8'h00, 8'hFF);
    check("async_reset_leds", leds, 8'h00, 8'hFF);
    @(negedge clk);
    notReset = 1'b1;
    req0 = 1'b1; req1 = 1'b1;
    @(posedge clk);
    #1;
    check("tie_after_reset_gnt0", {7'b0, gnt0}, 8'h01, 8'hFF);
    check("tie_after_reset_gnt1", {7'b0, gnt1}, 8'h00, 8'hFF);

    // Idle LEDs with no requests: blink on LED0 when the heartbeat is built
    // in, otherwise dark.
    doReset();
    for (int k = 1; k <= 12; k++) begin
      logic [7:0] want;
      @(posedge clk);
      #1;
`ifdef LED_BANK_IDLE_HEARTBEAT_EN
      want = {7'b0, 1'(((k - 1) / HoldCycles) % 2)};
`else
      want = 8'h00;
`endif
      check($sformatf("idle_leds_cycle%0d", k), leds, want, 8'hFF);
    end

    $display("%0d/%0d checks passed", passCount, checkCount);
    $finish;
  end

endmodule
